// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Byte-level protocol stage behind an SPI slave shift register. Synchronises
//   the slave's chip select and byte strobe into clk, then decodes the
//   command byte. The command selects write (bit WIDTH-1 = 1) or read and a
//   start address. The rest of the frame streams auto-incrementing register
//   accesses. The block also supplies the slave's next MISO byte.
//
//   Optional build macro: SPI_REG_BRIDGE_STATUS_EN
//     When defined, the idle MISO byte becomes a status byte
//     {cs_err, write_frame_count[WIDTH-2:0]} instead of IDLE_BYTE.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   cs           SPI chip select, active low, asynchronous
//   rx_data      received byte from the slave (stable across the next byte)
//   rx_strobe    byte-complete strobe from the slave, asynchronous
//   tx_data      next MISO byte, loaded by the slave after each byte
//   reg_addr     register file address
//   reg_wr_en    one-cycle write pulse
//   reg_wr_data  write data, valid with reg_wr_en
//   reg_rd_en    one-cycle read pulse
//   reg_rd_data  combinational read data, sampled while reg_rd_en is high
//   frame_active high while a frame is being decoded
module spi_reg_bridge #(
  parameter int              WIDTH       = 8,
  parameter int              ADDR_W      = 4,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [WIDTH-1:0]  rx_data,
  input  logic              rx_strobe,
  output logic [WIDTH-1:0]  tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [WIDTH-1:0]  reg_wr_data,
  output logic              reg_rd_en,
  input  logic [WIDTH-1:0]  reg_rd_data,
  output logic              frame_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t state_r, state_nx;

  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] stb_sync_r;
  logic                   cs_prev_r;
  logic                   stb_prev_r;
  logic                   cs_s;
  logic                   stb_s;
  logic                   byte_ev_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;

  logic [WIDTH-1:0]  hold_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] reg_addr_r;
  logic              wr_en_r;
  logic              rd_en_r;
  logic [WIDTH-1:0]  tx_r;
  logic              frame_active_r;

  logic              wr_fire_s;
  logic              rd_fire_s;
  logic              cmd_load_s;
  logic [WIDTH-1:0]  status_s;

  // Synchroniser chains plus one extra flop each for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_r  <= {SYNC_STAGES{1'b1}};
      stb_sync_r <= {SYNC_STAGES{1'b0}};
      cs_prev_r  <= 1'b1;
      stb_prev_r <= 1'b0;
    end else begin
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      stb_sync_r <= {stb_sync_r[SYNC_STAGES-2:0], rx_strobe};
      cs_prev_r  <= cs_s;
      stb_prev_r <= stb_s;
    end
  end

  assign cs_s      = cs_sync_r[SYNC_STAGES-1];
  assign stb_s     = stb_sync_r[SYNC_STAGES-1];
  assign byte_ev_s = stb_s & ~stb_prev_r;
  assign cs_rise_s = cs_s & ~cs_prev_r;
  assign cs_fall_s = ~cs_s & cs_prev_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state and access decode. rx_data is still stable in the byte-event
  // cycle, so the command is decoded straight from it.
  always_comb begin
    state_nx   = state_r;
    wr_fire_s  = 1'b0;
    rd_fire_s  = 1'b0;
    cmd_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nx = ST_CMD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (cs_rise_s) begin
          // Frame closed at or before the command byte: no access at all.
          state_nx = ST_IDLE;
        end else if (byte_ev_s) begin
          cmd_load_s = 1'b1;
          if (rx_data[WIDTH-1]) begin
            state_nx = ST_WRITE;
          end else begin
            state_nx  = ST_READ;
            rd_fire_s = 1'b1;
          end
        end else begin
          state_nx = ST_CMD;
        end
      end
      ST_WRITE: begin
        // A byte coinciding with cs rise is still written before leaving.
        wr_fire_s = byte_ev_s;
        if (cs_rise_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WRITE;
        end
      end
      ST_READ: begin
        rd_fire_s = byte_ev_s;
        if (cs_rise_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_READ;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

`ifdef SPI_REG_BRIDGE_STATUS_EN
  localparam logic [WIDTH-1:0] TX_RST = {WIDTH{1'b0}};

  logic [WIDTH-1:0] wr_cnt_r;
  logic             cs_err_r;
  logic             wrote_r;

  // Completed-write-frame counter and sticky empty-frame flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_r <= {WIDTH{1'b0}};
      cs_err_r <= 1'b0;
      wrote_r  <= 1'b0;
    end else begin
      if (state_r == ST_WRITE && byte_ev_s) begin
        wrote_r <= 1'b1;
      end else if (state_r == ST_IDLE) begin
        wrote_r <= 1'b0;
      end
      if (state_r == ST_WRITE && cs_rise_s && (wrote_r || byte_ev_s)) begin
        wr_cnt_r <= wr_cnt_r + WIDTH'(1);
      end
      if (state_r == ST_CMD && cs_rise_s && !byte_ev_s) begin
        cs_err_r <= 1'b1;
      end
    end
  end

  assign status_s = {cs_err_r, wr_cnt_r[WIDTH-2:0]};
`else
  localparam logic [WIDTH-1:0] TX_RST = IDLE_BYTE;

  assign status_s = IDLE_BYTE;
`endif

  // Datapath: byte hold, address pointer, access strobes and MISO byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r         <= {WIDTH{1'b0}};
      ptr_r          <= {ADDR_W{1'b0}};
      reg_addr_r     <= {ADDR_W{1'b0}};
      wr_en_r        <= 1'b0;
      rd_en_r        <= 1'b0;
      tx_r           <= TX_RST;
      frame_active_r <= 1'b0;
    end else begin
      if (byte_ev_s) begin
        hold_r <= rx_data;
      end
      wr_en_r <= wr_fire_s;
      rd_en_r <= rd_fire_s;
      // The command read uses the freshly decoded address, later accesses
      // use the running pointer; reg_addr otherwise holds its last value.
      if (wr_fire_s || rd_fire_s) begin
        reg_addr_r <= cmd_load_s ? rx_data[ADDR_W-1:0] : ptr_r;
      end
      if (cmd_load_s) begin
        ptr_r <= rx_data[ADDR_W-1:0];
      end else if (wr_en_r || rd_en_r) begin
        ptr_r <= ptr_r + ADDR_W'(1);
      end
      // Read data wins even on the way back to IDLE; the idle byte follows.
      if (rd_en_r) begin
        tx_r <= reg_rd_data;
      end else if (state_r == ST_IDLE) begin
        tx_r <= status_s;
      end
      frame_active_r <= (state_nx != ST_IDLE);
    end
  end

  assign tx_data      = tx_r;
  assign reg_addr     = reg_addr_r;
  assign reg_wr_en    = wr_en_r;
  assign reg_wr_data  = hold_r;
  assign reg_rd_en    = rd_en_r;
  assign frame_active = frame_active_r;

endmodule
